// File: rtl/ppu_requant_if.sv
// Output stream of the requantizer: one signed lane word per handshake.
interface ppu_requant_if #(
   parameter int unsigned OUT_W  = 8,
   parameter int unsigned LANE_W = 3
);
   logic              valid;
   logic              ready;
   logic [OUT_W-1:0]  data;
   logic [LANE_W-1:0] lane;
   logic              last;

   modport master (output valid, data, lane, last, input ready);
   modport slave  (input valid, data, lane, last, output ready);
endinterface

// File: rtl/ppu_requant.sv
// Post-processing requantizer: tracks the running |max| of accumulator tiles and
// emits one rounded, saturated INT8/INT4 word per lane over a ready/valid stream.
module ppu_requant #(
   parameter int unsigned VL    = 8,
   parameter int unsigned ACC_W = 24,
   parameter int unsigned OUT_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [ACC_W*VL-1:0]   i_acc_data,
   input  logic [1:0]            i_mode,
   input  logic                  i_max_pass,
   input  logic                  i_clr,
   ppu_requant_if.master         o_out,
   output logic                  o_busy,
   output logic                  o_drop
);
   localparam int unsigned LANE_W = (VL > 1) ? $clog2(VL) : 1;
   localparam int unsigned SH_W   = $clog2(ACC_W + 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VL - 1);

   typedef enum logic [1:0] {IDLE, SCALE, OUT} state_e;
   typedef enum logic [1:0] {MODE_INT8, MODE_INT4, MODE_INT4_VSQ, MODE_RSVD} mode_e;

   state_e              state_r, state_nxt;
   mode_e               mode_r;
   logic [ACC_W-1:0]    acc_r [VL];
   logic [ACC_W-1:0]    max_r, max_nxt;
   logic [ACC_W-1:0]    lane_v, lane_abs;
   logic [SH_W-1:0]     shift_r, shift_nxt, bit_len, thr_m1;
   logic [LANE_W-1:0]   lane_r;
   logic                start_max, start_calc, hs, int4, out_valid;
   logic [ACC_W-1:0]    acc_sel;
   logic signed [ACC_W:0] acc_ext, rnd, res, sat_hi, sat_lo, sat_v;

   assign start_max  = i_start && i_max_pass && (state_r == IDLE);
   assign start_calc = i_start && !i_max_pass && (state_r == IDLE);
   assign out_valid  = (state_r == OUT);
   assign hs         = out_valid && o_out.ready;
   assign int4       = (mode_r == MODE_INT4) || (mode_r == MODE_INT4_VSQ);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_r <= IDLE;
      else          state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      o_busy    = (state_r != IDLE);
      o_drop    = i_start && (state_r != IDLE);
      case (state_r)
         IDLE:    if (start_calc) state_nxt = SCALE;
         SCALE:   state_nxt = OUT;
         OUT:     if (hs && (lane_r == LAST_LANE)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Clear is applied before folding in lanes so clr+max-pass sees only this tile.
   always_comb begin
      max_nxt  = i_clr ? '0 : max_r;
      lane_v   = '0;
      lane_abs = '0;
      if (start_max) begin
         for (int unsigned k = 0; k < VL; k++) begin
            lane_v   = i_acc_data[k*ACC_W +: ACC_W];
            lane_abs = lane_v[ACC_W-1] ? (~lane_v + ACC_W'(1)) : lane_v;
            if (lane_abs > max_nxt) max_nxt = lane_abs;
         end
      end
   end

   always_comb begin
      bit_len = '0;
      for (int unsigned i = 0; i < ACC_W; i++) begin
         if (max_r[i]) bit_len = SH_W'(i + 1);
      end
      thr_m1    = int4 ? SH_W'(3) : SH_W'(7);
      shift_nxt = '0;
      if ((mode_r != MODE_INT4_VSQ) && (bit_len > thr_m1)) shift_nxt = bit_len - thr_m1;
   end

   // One guard bit above ACC_W keeps the rounding add from overflowing.
   always_comb begin
      acc_sel = acc_r[lane_r];
      acc_ext = {acc_sel[ACC_W-1], acc_sel};
      rnd     = '0;
      res     = acc_ext;
      if (shift_r != '0) begin
         rnd = (ACC_W+1)'(1) <<< (shift_r - SH_W'(1));
         res = (acc_ext + rnd) >>> shift_r;
      end
      sat_hi = int4 ? (ACC_W+1)'(7) : (ACC_W+1)'(127);
      sat_lo = int4 ? -(ACC_W+1)'(8) : -(ACC_W+1)'(128);
      if (res > sat_hi)      sat_v = sat_hi;
      else if (res < sat_lo) sat_v = sat_lo;
      else                   sat_v = res;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode_r  <= MODE_INT8;
         max_r   <= '0;
         shift_r <= '0;
         lane_r  <= '0;
         for (int unsigned k = 0; k < VL; k++) acc_r[k] <= '0;
      end else begin
         if (start_max || i_clr) max_r <= max_nxt;
         if (start_calc) begin
            mode_r <= mode_e'(i_mode);
            for (int unsigned k = 0; k < VL; k++) acc_r[k] <= i_acc_data[k*ACC_W +: ACC_W];
         end
         if (state_r == SCALE) begin
            shift_r <= shift_nxt;
            lane_r  <= '0;
         end else if (hs) begin
            lane_r <= (lane_r == LAST_LANE) ? '0 : lane_r + LANE_W'(1);
         end
      end
   end

   assign o_out.valid = out_valid;
   assign o_out.data  = out_valid ? sat_v[OUT_W-1:0] : '0;
   assign o_out.lane  = out_valid ? lane_r : '0;
   assign o_out.last  = out_valid && (lane_r == LAST_LANE);
endmodule

// File: tb/tb_ppu_requant.sv
// Directed bench for ppu_requant: max/calc passes, all modes, stalls, drops, resets.
module tb_ppu_requant;
   localparam int unsigned VL    = 8;
   localparam int unsigned ACC_W = 24;
   localparam int unsigned OUT_W = 8;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_start = 1'b0;
   logic              i_max_pass = 1'b0;
   logic              i_clr = 1'b0;
   logic [1:0]        i_mode = '0;
   logic [ACC_W*VL-1:0] i_acc_data = '0;
   logic              o_busy, o_drop;

   int                n_checks = 0;
   int                n_errors = 0;
   int                lanes [VL];
   logic [7:0]        exp_q [VL];

   ppu_requant_if #(.OUT_W(OUT_W), .LANE_W(3)) out_if ();

   ppu_requant #(.VL(VL), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_acc_data (i_acc_data),
      .i_mode     (i_mode),
      .i_max_pass (i_max_pass),
      .i_clr      (i_clr),
      .o_out      (out_if),
      .o_busy     (o_busy),
      .o_drop     (o_drop)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic load_lanes();
      for (int k = 0; k < VL; k++) i_acc_data[k*ACC_W +: ACC_W] = ACC_W'(lanes[k]);
   endtask

   task automatic max_pass(input logic clr);
      load_lanes();
      i_start = 1'b1; i_max_pass = 1'b1; i_clr = clr;
      #1;
      check("mp_drop", o_drop, 0);
      tick();
      i_start = 1'b0; i_max_pass = 1'b0; i_clr = 1'b0;
      #1;
      check("mp_valid", out_if.valid, 0);
      check("mp_busy", o_busy, 0);
   endtask

   // Expected words come from exp_q; lane index -1 disables stall/drop/clr.
   task automatic run_tile(input logic [1:0] mode, input int stall_lane,
                           input int drop_lane, input int clr_lane);
      load_lanes();
      i_mode = mode; i_start = 1'b1; i_max_pass = 1'b0; out_if.ready = 1'b1;
      #1;
      check("n0_busy", o_busy, 0);
      tick();
      i_start = 1'b0;
      #1;
      check("n1_valid", out_if.valid, 0);
      check("n1_busy", o_busy, 1);
      tick();
      for (int i = 0; i < VL; i++) begin
         if (i == stall_lane) begin
            out_if.ready = 1'b0;
            repeat (3) begin
               #1;
               check($sformatf("stall_lane_l%0d", i), out_if.lane, i);
               check($sformatf("stall_data_l%0d", i), out_if.data, exp_q[i]);
               check("stall_valid", out_if.valid, 1);
               tick();
            end
            out_if.ready = 1'b1;
         end
         if (i == drop_lane) begin i_start = 1'b1; i_max_pass = 1'b1; end
         if (i == clr_lane) i_clr = 1'b1;
         #1;
         check($sformatf("valid_l%0d", i), out_if.valid, 1);
         check($sformatf("lane_l%0d", i), out_if.lane, i);
         check($sformatf("data_l%0d", i), out_if.data, exp_q[i]);
         check($sformatf("last_l%0d", i), out_if.last, (i == VL - 1) ? 1 : 0);
         check($sformatf("drop_l%0d", i), o_drop, (i == drop_lane) ? 1 : 0);
         tick();
         i_start = 1'b0; i_max_pass = 1'b0; i_clr = 1'b0;
      end
      #1;
      check("end_valid", out_if.valid, 0);
      check("end_busy", o_busy, 0);
      check("end_drop", o_drop, 0);
   endtask

   initial begin
      out_if.ready = 1'b1;
      #3;
      check("rst_valid", out_if.valid, 0);
      check("rst_data", out_if.data, 0);
      check("rst_lane", out_if.lane, 0);
      check("rst_last", out_if.last, 0);
      check("rst_busy", o_busy, 0);
      check("rst_drop", o_drop, 0);
      check("rst_max", dut.max_r, 0);
      #20 i_rst_n = 1'b1;
      tick();

      lanes = '{default: 0}; lanes[0] = 100; lanes[1] = -300;
      max_pass(1'b1);
      check("max_300", dut.max_r, 300);

      exp_q = '{default: 8'h00}; exp_q[0] = 8'h19; exp_q[1] = 8'hB5;
      run_tile(2'd0, -1, -1, -1);

      lanes = '{default: 0};
      lanes[0] = 100; lanes[1] = -300; lanes[2] = 1000; lanes[3] = -1000;
      exp_q = '{default: 8'h00};
      exp_q[0] = 8'h02; exp_q[1] = 8'hFB; exp_q[2] = 8'h07; exp_q[3] = 8'hF8;
      run_tile(2'd1, 2, 5, -1);
      check("max_after_drop", dut.max_r, 300);

      lanes = '{default: 0}; lanes[0] = 20; lanes[1] = -20; lanes[2] = 5;
      exp_q = '{default: 8'h00}; exp_q[0] = 8'h07; exp_q[1] = 8'hF8; exp_q[2] = 8'h05;
      run_tile(2'd2, -1, -1, 3);
      check("max_clr_busy", dut.max_r, 0);

      lanes = '{default: 0};
      lanes[0] = 200; lanes[1] = -200; lanes[2] = 127; lanes[3] = -128; lanes[4] = 1;
      exp_q = '{default: 8'h00};
      exp_q[0] = 8'h7F; exp_q[1] = 8'h80; exp_q[2] = 8'h7F; exp_q[3] = 8'h80; exp_q[4] = 8'h01;
      run_tile(2'd3, -1, -1, -1);

      lanes = '{default: 0}; lanes[0] = -8388608; lanes[1] = 8388607;
      max_pass(1'b0);
      check("max_neg_full", dut.max_r, 32'h0080_0000);
      lanes = '{default: 0}; lanes[0] = 5;
      max_pass(1'b0);
      check("max_persist", dut.max_r, 32'h0080_0000);

      lanes = '{default: 0};
      lanes[0] = -8388608; lanes[1] = 8388607; lanes[2] = 65535;
      lanes[3] = -65537; lanes[4] = 65536;
      exp_q = '{default: 8'h00};
      exp_q[0] = 8'hC0; exp_q[1] = 8'h40; exp_q[2] = 8'h00; exp_q[3] = 8'hFF; exp_q[4] = 8'h01;
      run_tile(2'd0, -1, -1, -1);

      load_lanes();
      i_mode = 2'd0; i_start = 1'b1; i_max_pass = 1'b0;
      tick();
      i_start = 1'b0;
      repeat (5) tick();
      check("pre_rst_lane", out_if.lane, 4);
      i_rst_n = 1'b0;
      #1;
      check("arst_valid", out_if.valid, 0);
      check("arst_data", out_if.data, 0);
      check("arst_lane", out_if.lane, 0);
      check("arst_last", out_if.last, 0);
      check("arst_busy", o_busy, 0);
      check("arst_max", dut.max_r, 0);
      tick();
      i_rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("post_rst_valid_c%0d", c), out_if.valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ppu_requant.md
PPU_REQUANT -- requirements
Module: ppu_requant

Interface
REQ-001 Parameter VL, 8, accumulator lanes per tile row.
REQ-002 Parameter ACC_W, 24, signed accumulator width per lane.
REQ-003 Parameter OUT_W, 8, output word width; INT4 results are sign-extended into it.
REQ-004 i_clk  in  1  clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  one-cycle pulse; i_acc_data is valid in the same cycle.
REQ-007 i_acc_data  in  ACC_W*VL  signed lane sums; lane k occupies bits [k*ACC_W +: ACC_W].
REQ-008 i_mode  in  2  mode: 0=INT8, 1=INT4, 2=INT4_VSQ, 3=reserved (treated as INT8).
REQ-009 i_max_pass  in  1  1=max-collection pass, 0=requantize pass; sampled with i_start.
REQ-010 i_clr  in  1  clears the running maximum.
REQ-011 o_valid  out  1  o_data/o_lane valid.
REQ-012 i_ready  in  1  consumer accepts when o_valid&&i_ready.
REQ-013 o_data  out  OUT_W  requantized signed lane value.
REQ-014 o_lane  out  log2(VL)  lane index of o_data.
REQ-015 o_last  out  1  high with o_valid on lane VL-1.
REQ-016 o_busy  out  1  high whenever state is not IDLE.
REQ-017 o_drop  out  1  one-cycle pulse when i_start is ignored.

Function
REQ-018 States: IDLE, SCALE, OUT; reset state IDLE.
REQ-019 IDLE with i_start&&i_max_pass: max_r <= max(max_r, |lane 0..VL-1|), computed in a single cycle, unsigned ACC_W bits (|-2^(ACC_W-1)| = 2^(ACC_W-1)); state stays IDLE; no output.
REQ-020 i_clr: max_r <= 0; if asserted with a max-pass i_start, the new max is the max of the current lanes only.
REQ-021 IDLE with i_start&&!i_max_pass: latch all lanes and i_mode into internal registers -> SCALE.
REQ-022 SCALE (1 cycle): T=8 for INT8, T=4 for INT4/INT4_VSQ; L=bit length of max_r (0 if max_r=0); shift = max(0, L-(T-1)) for INT8/INT4; shift=0 for INT4_VSQ -> OUT with lane=0.
REQ-023 Latency: i_start in cycle n -> o_valid high in cycle n+2 with lane 0.
REQ-024 Per lane: r = shift? (acc + 2^(shift-1)) >>> shift : acc, computed at ACC_W+1 bits without overflow; saturate to [-2^(T-1), 2^(T-1)-1]; sign-extend to OUT_W.
REQ-025 OUT: o_valid=1; o_data/o_lane/o_last are held stable while !i_ready; on handshake lane++; on handshake at lane VL-1 -> IDLE, o_valid=0 in the next cycle.
REQ-026 i_start while o_busy: ignored (no latch, max_r unchanged), o_drop=1 for that cycle; the current output sequence is unaffected.
REQ-027 i_clr while busy: clears max_r; the shift already computed for the current tile is unchanged.
REQ-028 max_r persists across calc passes until i_clr or reset.

Reset
REQ-029 On i_rst_n low, immediately: state IDLE, max_r=0, lane=0, o_valid=0, o_data=0, o_lane=0, o_last=0, o_busy=0, o_drop=0.
REQ-030 Reset during OUT aborts the tile; no remaining lanes are emitted after release.

Verification
REQ-031 i_clr; max pass with lane0=100, lane1=-300, others 0; calc pass with the same data, INT8 -> shift=2, outputs lane0=25, lane1=-75, others 0, o_last on lane 7.
REQ-032 INT4_VSQ calc with lane0=20, lane1=-20, lane2=5 -> outputs 7, -8 (0xF8), 5; shift is 0 regardless of max_r.
REQ-033 i_start at cycle n with i_ready=1 -> o_valid at n+2; 8 lanes on consecutive cycles; o_busy low at n+10.
REQ-034 i_ready held low 3 cycles while lane 2 is presented -> o_data/o_lane unchanged for those cycles; lane 3 follows the handshake.
REQ-035 i_start during OUT -> o_drop=1 for one cycle, max_r and the output sequence unchanged.
REQ-036 Reset asserted at lane 4 of OUT -> all outputs 0 and max_r=0 at once; after release o_valid stays 0 until the next i_start.
